reg_text_writer: RTL and testbench
==================================

Name: reg_text_writer

Overview:
- Sequential upstream stage for the ASCII text controller in the register-debug display.
- Takes one 32-bit two's-complement word and a screen position, converts it to signed decimal with a shift-add-3 (double-dabble) engine, then streams 11 character writes in the controller's write format.
- Replaces the wide combinational divide/modulo digit extraction with a 32-cycle iterative converter.
- A sequencer above it walks x0..x31 and pc, one row each.

Parameters:
- COLS, 80: characters per screen row; used for address generation.
- ADDR_W, 13: width of the character write address.
- ATTR, 24'hFFFFFF: attribute/colour bits placed in ascii_input[23:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  32  word to display, two's complement; captured with start.
- row  input  6  screen row (0..63); captured with start.
- col_base  input  7  first column of the 11-character field; captured with start.
- busy  output  1  high in SHIFT and EMIT.
- done  output  1  one-cycle pulse after the last write.
- sign_out  output  1  captured value[31].
- bcd_out  output  40  ten BCD digits of the magnitude, most significant digit in [39:36].
- ascii_write_en  output  1  character write strobe.
- ascii_input  output  32  {ascii_char, ATTR}.
- ascii_write_address  output  ADDR_W  row*COLS + col_base + k, truncated to ADDR_W.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy, done, sign_out, ascii_write_en = 0. bcd_out, ascii_input, ascii_write_address = 0. Bit and char counters = 0.
- States and transitions:
  - IDLE: on start=1, go to SHIFT.
  - SHIFT: stay 32 cycles, then go to EMIT.
  - EMIT: stay 11 cycles, then go to DONE.
  - DONE: stay 1 cycle, then go to IDLE.
- Capture (edge leaving IDLE):
  - sign_out <= value[31].
  - mag <= value[31] ? (~value+1) : value, as a 32-bit unsigned. 0x80000000 gives mag 2147483648.
  - BCD accumulator cleared; latch row and col_base.
- SHIFT, each cycle:
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, mag} shifts left by 1.
  - Exactly 32 iterations; 10 digits are sufficient for any 32-bit magnitude.
  - bcd_out is updated when the state enters EMIT.
- EMIT, char index k=0..10, one per cycle:
  - ascii_write_en=1 and all outputs registered.
  - k=0: char is 0x2D ('-') if sign_out, else 0x2B ('+').
  - k=1..10: char is 0x30 + digit, from the most significant digit down. Leading zeros are kept.
  - Address = row*COLS + col_base + k, computed at ADDR_W+1 bits and truncated. Wrap past 2^ADDR_W is not flagged.
- Timing, with start high in cycle 0:
  - busy=1 in cycles 1..43.
  - SHIFT occupies cycles 1..32.
  - Writes occur in cycles 33..43.
  - done=1 in cycle 44 (busy=0).
  - IDLE resumes in cycle 45.
- Outside EMIT:
  - ascii_write_en=0.
  - ascii_input and ascii_write_address hold their last value.
  - sign_out and bcd_out hold until the next capture.
- start outside IDLE (SHIFT, EMIT, DONE) is ignored, with no queueing. If start is held high, a new run begins at cycle 45.
- value, row and col_base changes after capture have no effect.
- Reset mid-operation: outputs return to reset values immediately and no further writes are issued. The next start runs cleanly.

Test Plan:
1. value=0, row=0, col_base=0, start pulse in cycle 0 -> cycles 33..43 write addr 0..10; data 0x2BFFFFFF then ten writes of 0x30FFFFFF; done only in cycle 44; bcd_out=0.
2. value=32'hFFFFFFFF, row=3, col_base=0 -> addr 240..250; chars "-0000000001"; sign_out=1; bcd_out=40'h0000000001.
3. value=32'h80000000, row=5, col_base=20 -> addr 420..430; chars "-2147483648"; bcd_out=40'h2147483648.
4. value=32'h7FFFFFFF, row=32, col_base=0 -> addr 2560..2570; chars "+2147483647"; busy high for exactly 43 cycles.
5. start re-pulsed in cycle 10 with value=5 while converting 1234 -> output remains "+0000001234"; exactly 11 writes; one done.
6. rst pulsed high during the 6th write cycle -> ascii_write_en and busy drop without waiting for clk; no further writes. Then start with value=42 -> "+0000000042" with nominal timing.

Source files
------------

// File: rtl/reg_text_writer.sv
// Register-debug text stage: turns a 32-bit signed word into an 11-character
// "+dddddddddd" field using a 32-cycle shift-add-3 converter, then streams the characters.
module reg_text_writer #(
  parameter int          COLS   = 80,
  parameter int          ADDR_W = 13,
  parameter logic [23:0] ATTR   = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       value,
  input  logic [5:0]        row,
  input  logic [6:0]        col_base,
  output logic              busy,
  output logic              done,
  output logic              sign_out,
  output logic [39:0]       bcd_out,
  output logic              ascii_write_en,
  output logic [31:0]       ascii_input,
  output logic [ADDR_W-1:0] ascii_write_address
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next magnitude bit.
  // The carry out of the top digit is dropped; ten digits always hold a 32-bit magnitude.
  function automatic logic [39:0] dabble_step(input logic [39:0] bcd, input logic in_bit);
    logic [39:0] res;
    logic [3:0]  dig;
    logic        carry;
    res   = 40'd0;
    carry = in_bit;
    for (int i = 0; i < 10; i++) begin
      dig = bcd[4*i +: 4];
      if (dig >= 4'd5) begin
        dig = dig + 4'd3;
      end else begin
        dig = dig;
      end
      res[4*i +: 4] = {dig[2:0], carry};
      carry         = dig[3];
    end
    return res;
  endfunction

  state_t              state_r;
  logic [4:0]          bit_cnt_r;
  logic [3:0]          char_cnt_r;
  logic [31:0]         mag_r;
  logic [39:0]         bcd_r;
  logic [5:0]          row_r;
  logic [6:0]          col_r;
  logic                busy_r;
  logic                done_r;
  logic                sign_r;
  logic [39:0]         bcd_out_r;
  logic                wr_en_r;
  logic [31:0]         wr_data_r;
  logic [ADDR_W-1:0]   wr_addr_r;

  logic [39:0]         bcd_next_s;
  logic [3:0]          k_s;
  logic [5:0]          dig_lsb_s;
  logic [3:0]          digit_s;
  logic [7:0]          char_s;
  logic [ADDR_W-1:0]   addr_s;

  assign bcd_next_s = dabble_step(bcd_r, mag_r[31]);
  assign k_s        = (state_r == ST_EMIT) ? char_cnt_r : 4'd0;
  assign dig_lsb_s  = 6'd40 - {k_s, 2'b00};
  assign digit_s    = bcd_out_r[dig_lsb_s +: 4];
  // Modulo-2^ADDR_W arithmetic gives the same result as a wider sum truncated afterwards.
  assign addr_s     = ADDR_W'(row_r) * ADDR_W'(COLS) + ADDR_W'(col_r) + ADDR_W'(k_s);

  // Character for the current field position: sign first, then digits most significant first.
  always_comb begin
    char_s = 8'h20;
    if (k_s == 4'd0) begin
      if (sign_r) begin
        char_s = 8'h2D;
      end else begin
        char_s = 8'h2B;
      end
    end else if (k_s <= 4'd10) begin
      char_s = 8'h30 + {4'h0, digit_s};
    end else begin
      char_s = 8'h20;
    end
  end

  // Control FSM with capture, conversion datapath and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 5'd0;
      char_cnt_r <= 4'd0;
      mag_r      <= 32'd0;
      bcd_r      <= 40'd0;
      row_r      <= 6'd0;
      col_r      <= 7'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sign_r     <= 1'b0;
      bcd_out_r  <= 40'd0;
      wr_en_r    <= 1'b0;
      wr_data_r  <= 32'd0;
      wr_addr_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r  <= 1'b0;
          wr_en_r <= 1'b0;
          if (start) begin
            sign_r     <= value[31];
            mag_r      <= value[31] ? (~value + 32'd1) : value;
            bcd_r      <= 40'd0;
            row_r      <= row;
            col_r      <= col_base;
            bit_cnt_r  <= 5'd0;
            char_cnt_r <= 4'd0;
            busy_r     <= 1'b1;
            state_r    <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          bcd_r     <= bcd_next_s;
          mag_r     <= {mag_r[30:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + 5'd1;
          // The last iteration also launches the sign character so writes start on the next cycle.
          if (bit_cnt_r == 5'd31) begin
            bcd_out_r  <= bcd_next_s;
            wr_en_r    <= 1'b1;
            wr_data_r  <= {char_s, ATTR};
            wr_addr_r  <= addr_s;
            char_cnt_r <= 4'd1;
            state_r    <= ST_EMIT;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_EMIT: begin
          if (char_cnt_r == 4'd11) begin
            wr_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            char_cnt_r <= 4'd0;
            state_r    <= ST_DONE;
          end else begin
            wr_en_r    <= 1'b1;
            wr_data_r  <= {char_s, ATTR};
            wr_addr_r  <= addr_s;
            char_cnt_r <= char_cnt_r + 4'd1;
            state_r    <= ST_EMIT;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          wr_en_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy                = busy_r;
  assign done                = done_r;
  assign sign_out            = sign_r;
  assign bcd_out             = bcd_out_r;
  assign ascii_write_en      = wr_en_r;
  assign ascii_input         = wr_data_r;
  assign ascii_write_address = wr_addr_r;

endmodule

// File: tb/tb_reg_text_writer.sv
// Scoreboard bench for reg_text_writer: stimulus pushes expected writes/done events,
// a negedge monitor pops and compares them against DUT activity.
module tb_reg_text_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic [5:0]  row;
  logic [6:0]  col_base;
  logic        busy;
  logic        done;
  logic        sign_out;
  logic [39:0] bcd_out;
  logic        ascii_write_en;
  logic [31:0] ascii_input;
  logic [12:0] ascii_write_address;

  reg_text_writer dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .row(row), .col_base(col_base),
    .busy(busy), .done(done), .sign_out(sign_out), .bcd_out(bcd_out),
    .ascii_write_en(ascii_write_en), .ascii_input(ascii_input),
    .ascii_write_address(ascii_write_address)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] data; logic [12:0] addr; } wr_t;
  typedef struct { int cyc; logic sign; logic [39:0] bcd; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  run_c0 = -1;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Decimal digits of |v| by plain division, packed as BCD.
  function automatic logic [39:0] ref_bcd(input logic [31:0] v);
    longint m;
    logic [39:0] res;
    m = longint'({32'd0, v});
    if (v[31]) m = 64'sh1_0000_0000 - m;
    res = 40'd0;
    for (int i = 0; i < 10; i++) begin
      res[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return res;
  endfunction

  function automatic logic [7:0] ref_char(input logic neg, input logic [39:0] b, input int k);
    if (k == 0) return neg ? 8'h2D : 8'h2B;
    return 8'h30 + {4'h0, b[4*(10-k) +: 4]};
  endfunction

  // Monitor: compares busy every cycle and pops expected writes/done when the DUT presents them.
  always @(negedge clk) begin : monitor
    wr_t w;
    dn_t d;
    if (!rst) begin
      check("busy", 64'(busy), 64'(run_c0 >= 0 && cyc >= run_c0 + 1 && cyc <= run_c0 + 43));
      if (ascii_write_en) begin
        if (wq.size() == 0) flag("unexpected_write");
        else begin
          w = wq.pop_front();
          check("write_cycle", 64'(cyc), 64'(w.cyc));
          check("write_data", 64'(ascii_input), 64'(w.data));
          check("write_addr", 64'(ascii_write_address), 64'(w.addr));
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        flag("missing_write");
        void'(wq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0) flag("unexpected_done");
        else begin
          d = dq.pop_front();
          check("done_cycle", 64'(cyc), 64'(d.cyc));
          check("sign_out", 64'(sign_out), 64'(d.sign));
          check("bcd_out", 64'(bcd_out), 64'(d.bcd));
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        flag("missing_done");
        void'(dq.pop_front());
      end
    end
  end

  // One conversion: start in cycle 0, optional ignored re-start and optional mid-run reset.
  task automatic run(input logic [31:0] v, input logic [5:0] r, input logic [6:0] c,
                     input int restart_at, input int rst_at);
    int c0;
    logic [39:0] b;
    wr_t w;
    dn_t d;
    @(posedge clk); #1;
    c0 = cyc;
    value = v; row = r; col_base = c; start = 1'b1;
    b = ref_bcd(v);
    for (int k = 0; k < 11; k++) begin
      w.cyc  = c0 + 33 + k;
      w.data = {ref_char(v[31], b, k), 24'hFFFFFF};
      w.addr = 13'((int'(r) * 80 + int'(c) + k) % 8192);
      wq.push_back(w);
    end
    d.cyc = c0 + 44; d.sign = v[31]; d.bcd = b;
    dq.push_back(d);
    run_c0 = c0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      start    = (n == restart_at);
      value    = (n == restart_at) ? 32'd5 : $urandom;
      row      = 6'($urandom);
      col_base = 7'($urandom);
      if (n == rst_at) begin
        #1 rst = 1'b1;
        #1;
        check("rst_write_en", 64'(ascii_write_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(ascii_write_address), 64'd0);
        wq.delete();
        dq.delete();
        run_c0 = -1;
        @(posedge clk); #1 rst = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; value = 32'd0; row = 6'd0; col_base = 7'd0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sign", 64'(sign_out), 64'd0);
    check("reset_we", 64'(ascii_write_en), 64'd0);
    check("reset_bcd", 64'(bcd_out), 64'd0);
    check("reset_data", 64'(ascii_input), 64'd0);
    check("reset_addr", 64'(ascii_write_address), 64'd0);
    @(negedge clk) rst = 1'b0;

    run(32'd0,          6'd0,  7'd0,  0, 0);
    run(32'hFFFFFFFF,   6'd3,  7'd0,  0, 0);
    run(32'h80000000,   6'd5,  7'd20, 0, 0);
    run(32'h7FFFFFFF,   6'd32, 7'd0,  0, 0);
    run(32'd1234,       6'd7,  7'd9,  10, 0);
    run(32'd987654,     6'd9,  7'd3,  0, 38);
    run(32'd42,         6'd1,  7'd60, 0, 0);
    run(32'd0,          6'd63, 7'd127, 0, 0);
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run($urandom, 6'($urandom_range(0, 63)), 7'($urandom_range(0, 127)), 0, 0);
    end

    repeat (3) @(posedge clk);
    check("writes_drained", 64'(wq.size()), 64'd0);
    check("done_drained", 64'(dq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
